hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, max consecutive mem_busy cycles before a timeout error; legal range 2..255.
REQ-002 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs1, id_rs2  input  5 each  IF/ID source register indices.
REQ-006 ex_rd  input  5  ID/EX destination register index.
REQ-007 ex_memRead  input  1  the ID/EX instruction is a load.
REQ-008 branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-009 mem_busy  input  1  data memory is not ready; MEM stage must hold.
REQ-010 pc_write, ifid_write, idex_write, exmem_write  output  1 each  stage register enables.
REQ-011 ifid_flush, idex_flush  output  1 each  replace stage contents with a NOP bubble.
REQ-012 mem_timeout  output  1  sticky error flag.
REQ-013 stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-014 The FSM SHALL have exactly four states: RUN, STALL, WAIT, FLUSH.
REQ-015 Outputs SHALL be combinational from state and current inputs (Mealy), with no added latency.
REQ-016 load_use SHALL be ex_memRead & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-017 Priority SHALL be mem_busy > branch_taken > load_use, evaluated in RUN, STALL and FLUSH.
REQ-018 When mem_busy=1 in any state:
  - all four write enables = 0;
  - both flushes = 0;
  - next state = WAIT.
REQ-019 In WAIT with mem_busy=1, the outputs of REQ-018 SHALL hold and the wait counter SHALL increment.
REQ-020 In WAIT with mem_busy=0:
  - all write enables = 1;
  - branch_taken=1 also raises both flushes and moves to FLUSH;
  - otherwise next state = RUN.
REQ-021 branch_taken=1 with no mem_busy SHALL give:
  - pc_write=1 and all write enables = 1;
  - ifid_flush=1 and idex_flush=1 for that single cycle;
  - next state = FLUSH.
REQ-022 load_use=1 with no mem_busy or branch, in RUN, SHALL give:
  - pc_write=0, ifid_write=0, idex_flush=1;
  - idex_write=1, exmem_write=1;
  - next state = STALL.
REQ-023 In FLUSH, load_use SHALL be ignored because IF/ID holds a bubble; the block returns to RUN unless REQ-017 selects otherwise.
REQ-024 STALL SHALL last exactly one cycle with all enables = 1 and no flush, then move to RUN; a second load_use there SHALL be ignored.
REQ-025 The wait counter SHALL be 8 bits and clear on any cycle where the state is not WAIT.
REQ-026 mem_timeout SHALL set in the cycle the wait counter reaches TIMEOUT-1 with mem_busy still 1, and stay set until reset; the pipeline continues to obey mem_busy.
REQ-027 Default outputs (RUN, no event) SHALL be: all enables = 1, all flushes = 0.

Reset
REQ-028 reset=1 at a clock edge SHALL force:
  - state = RUN;
  - wait counter = 0;
  - mem_timeout = 0;
  - stall_cycles = 0.
REQ-029 While reset=1, outputs SHALL be: all enables = 1, ifid_flush = 1, idex_flush = 1; reset overrides any event, including reset in mid-WAIT.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN:
  - defined: stall_cycles increments each cycle with pc_write=0 and saturates at all-ones;
  - undefined: stall_cycles is tied to 0 and no counter flops are built.

Verification
REQ-031 Load-use: ex_memRead=1, ex_rd=5, id_rs1=5 in RUN -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; next cycle STALL with all enables = 1; then RUN.
REQ-032 ex_rd=0: ex_memRead=1, ex_rd=0, id_rs2=0 -> no stall, outputs at default.
REQ-033 Branch during load_use: branch_taken=1 with load_use=1 -> ifid_flush=idex_flush=1, pc_write=1; next cycle in FLUSH, load_use=1 is ignored.
REQ-034 Timeout: mem_busy=1 for 20 cycles with TIMEOUT=16 -> enables = 0 throughout; mem_timeout rises after the 16th busy cycle and stays 1 after mem_busy drops; stall_cycles=20 with the macro defined.
REQ-035 Reset in WAIT: reset asserted on the 3rd busy cycle -> next cycle state RUN, mem_timeout=0, stall_cycles=0.
REQ-036 Saturation: with CNT_W=4, macro defined, 20 stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Resolves memory stalls, taken-branch flushes and load-use interlocks,
// flags a sticky memory timeout and optionally counts stall cycles.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall_cycles perf counter).
//
// state | meaning
// RUN   | normal flow, load-use detection active
// STALL | one-cycle bubble after a load-use hold, load-use ignored
// WAIT  | data memory busy, whole pipeline frozen
// FLUSH | IF/ID holds a bubble after a taken branch, load-use ignored
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, WAIT, FLUSH} state_t;

  // wait_cnt is one behind the busy-cycle count (the entry cycle is in RUN),
  // so the timeout fires when it steps onto TIMEOUT-1.
  localparam logic [7:0] TO_PRE = 8'(TIMEOUT - 2);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       load_use;

  assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state selection: mem_busy > branch_taken > load_use (RUN only)
  always_comb begin
    state_nxt = RUN;
    if (mem_busy)
      state_nxt = WAIT;
    else if (branch_taken)
      state_nxt = FLUSH;
    else if ((state == RUN) && load_use)
      state_nxt = STALL;
  end

  // Mealy outputs; reset forces a full bubble regardless of state
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if ((state == RUN) && load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Busy-cycle counter while waiting, saturating so it never wraps
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= 8'd0;
    else if ((state == WAIT) && mem_busy && (wait_cnt != 8'hFF))
      wait_cnt <= wait_cnt + 8'd1;
    else if ((state != WAIT) || !mem_busy)
      wait_cnt <= 8'd0;
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)
      mem_timeout <= 1'b0;
    else if ((state == WAIT) && mem_busy && (wait_cnt == TO_PRE))
      mem_timeout <= 1'b1;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles where the PC is held
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
